// File: rtl/i2s_tdm_frame_rx_pkg.sv
// Shared types and helpers for the I2S/LJ/TDM frame receiver.
//   fs_mode_e  : frame-sync style (50% LRCLK or TDM pulse)
//   rx_state_e : receiver framing state
//   frame_bits : bclk periods per frame
package i2s_rx_pkg;

  typedef enum logic {
    FS_LRCLK = 1'b0,  // frame starts on LRCLK falling edge
    FS_PULSE = 1'b1   // frame starts on sync pulse rising edge
  } fs_mode_e;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    RUN       = 2'd1,
    WAIT_SYNC = 2'd2
  } rx_state_e;

  function automatic int unsigned frame_bits(input int unsigned num_slots,
                                             input int unsigned slot_width);
    return num_slots * slot_width;
  endfunction

endpackage

// File: rtl/i2s_tdm_frame_rx_fsync.sv
// Frame-sync edge detector.
//   i2s_bclk    : bit clock (rising edge)
//   sys_rst     : async active-high reset
//   fs_i        : raw LRCLK / TDM sync
//   sync_edge_o : one-cycle pulse, registered, on the frame-start edge of fs_i
// The rising edge is used for pulse sync, the falling edge for LRCLK; the other
// edge is ignored.
module i2s_fsync_detect
  import i2s_rx_pkg::*;
#(
  parameter int unsigned FS_MODE = 0
) (
  input  logic i2s_bclk,
  input  logic sys_rst,
  input  logic fs_i,
  output logic sync_edge_o
);

  localparam fs_mode_e Mode = fs_mode_e'(FS_MODE[0]);

  logic fs_q;
  logic sync_edge_q;
  logic sync_edge_d;

  // Compare the newly sampled level against the previously registered one.
  always_comb begin
    sync_edge_d = 1'b0;
    if (Mode == FS_PULSE) begin
      sync_edge_d = fs_i & ~fs_q;
    end else begin
      sync_edge_d = ~fs_i & fs_q;
    end
  end

  always_ff @(posedge i2s_bclk or posedge sys_rst) begin
    if (sys_rst) begin
      fs_q        <= 1'b0;
      sync_edge_q <= 1'b0;
    end else begin
      fs_q        <= fs_i;
      sync_edge_q <= sync_edge_d;
    end
  end

  assign sync_edge_o = sync_edge_q;

endmodule

// File: rtl/i2s_tdm_frame_rx.sv
// Serial audio frame receiver (I2S, left-justified, TDM), i2s_bclk domain only.
//   i2s_bclk, sys_rst : clock, async active-high reset
//   i2s_fs, i2s_data  : frame sync and serial data
//   err_clr           : clears sticky error flags (a new error in the same cycle wins)
//   frame_data        : slot n at [n*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   frame_valid       : one-cycle pulse when frame_data updates
//   frame_seq         : wrapping count of emitted frames
//   locked            : LOCK_FRAMES consecutive on-time sync edges seen
//   err_short/err_long: sticky early / missing sync edge
// The sync edge is acted on one edge after it is sampled. Data is aligned to that
// point: with DATA_DELAY=1 the live pin is used, with DATA_DELAY=0 a one-bit
// register holds the bit that arrived together with the sync edge.
module i2s_tdm_frame_rx
  import i2s_rx_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 8,
  parameter int unsigned SLOT_WIDTH   = 32,
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned FS_MODE      = 0,
  parameter int unsigned DATA_DELAY   = 1,
  parameter int unsigned LOCK_FRAMES  = 4
) (
  input  logic                              i2s_bclk,
  input  logic                              sys_rst,
  input  logic                              i2s_fs,
  input  logic                              i2s_data,
  input  logic                              err_clr,
  output logic [NUM_SLOTS*SAMPLE_WIDTH-1:0] frame_data,
  output logic                              frame_valid,
  output logic [7:0]                        frame_seq,
  output logic                              locked,
  output logic                              err_short,
  output logic                              err_long
);

  localparam int unsigned FrameBits = frame_bits(NUM_SLOTS, SLOT_WIDTH);
  localparam int unsigned CntW      = $clog2(FrameBits + 1);
  localparam int unsigned BitW      = $clog2(SLOT_WIDTH);
  localparam int unsigned SlotW     = $clog2(NUM_SLOTS);
  localparam int unsigned LockW     = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned DataW     = NUM_SLOTS * SAMPLE_WIDTH;

  rx_state_e              state_q, state_d;
  logic [CntW-1:0]        per_cnt_q, per_cnt_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [SlotW-1:0]       slot_q, slot_d;
  logic [DataW-1:0]       acc_q, acc_d;
  logic [DataW-1:0]       frame_data_q, frame_data_d;
  logic                   frame_valid_q, frame_valid_d;
  logic [7:0]             seq_q, seq_d;
  logic                   locked_q, locked_d;
  logic [LockW-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   err_short_q, err_short_d;
  logic                   err_long_q, err_long_d;
  logic                   data_q;

  logic                   sync_c;
  logic                   tap_c;
  logic                   start_c;
  logic                   capture_c;
  logic                   emit_c;
  logic                   short_evt_c;
  logic                   long_evt_c;
  logic [BitW-1:0]        cap_bit_c;
  logic [SlotW-1:0]       cap_slot_c;

  i2s_fsync_detect #(
    .FS_MODE (FS_MODE)
  ) u_fsync (
    .i2s_bclk    (i2s_bclk),
    .sys_rst     (sys_rst),
    .fs_i        (i2s_fs),
    .sync_edge_o (sync_c)
  );

  // Data alignment tap for the configured data delay.
  assign tap_c = (DATA_DELAY == 0) ? data_q : i2s_data;

  // Framing FSM, bit/slot counters, assembly and flag next-state.
  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    bit_d         = bit_q;
    slot_d        = slot_q;
    acc_d         = acc_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    seq_d         = seq_q;
    locked_d      = locked_q;
    lock_cnt_d    = lock_cnt_q;
    start_c       = 1'b0;
    capture_c     = 1'b0;
    emit_c        = 1'b0;
    short_evt_c   = 1'b0;
    long_evt_c    = 1'b0;
    cap_bit_c     = bit_q;
    cap_slot_c    = slot_q;

    case (state_q)
      HUNT: begin
        locked_d   = 1'b0;
        lock_cnt_d = '0;
        if (sync_c) begin
          state_d = RUN;
          start_c = 1'b0 | 1'b1;
        end
      end
      RUN: begin
        if (sync_c) begin
          start_c = 1'b1;
          if (per_cnt_q == CntW'(FrameBits)) begin
            if (lock_cnt_q < LockW'(LOCK_FRAMES)) begin
              lock_cnt_d = lock_cnt_q + LockW'(1);
            end
            if (lock_cnt_d == LockW'(LOCK_FRAMES)) begin
              locked_d = 1'b1;
            end
          end else begin
            // Early edge, including one that lands on the last bit of the frame.
            short_evt_c = 1'b1;
            locked_d    = 1'b0;
            lock_cnt_d  = '0;
          end
        end else if (per_cnt_q == CntW'(FrameBits)) begin
          long_evt_c = 1'b1;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
          state_d    = WAIT_SYNC;
        end else begin
          capture_c = 1'b1;
          emit_c    = (per_cnt_q == CntW'(FrameBits - 1));
        end
      end
      WAIT_SYNC: begin
        if (sync_c) begin
          state_d    = RUN;
          start_c    = 1'b1;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    // A sync edge always restarts the frame at bit 0 of slot 0.
    if (start_c) begin
      capture_c  = 1'b1;
      cap_bit_c  = '0;
      cap_slot_c = '0;
      per_cnt_d  = CntW'(1);
    end else if (capture_c) begin
      per_cnt_d = per_cnt_q + CntW'(1);
    end

    if (capture_c) begin
      if (32'(cap_bit_c) < SAMPLE_WIDTH) begin
        for (int s = 0; s < int'(NUM_SLOTS); s++) begin
          if (cap_slot_c == SlotW'(s)) begin
            acc_d[s*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
              {acc_q[s*SAMPLE_WIDTH +: SAMPLE_WIDTH-1], tap_c};
          end
        end
      end
      if (cap_bit_c == BitW'(SLOT_WIDTH - 1)) begin
        bit_d  = '0;
        slot_d = cap_slot_c + SlotW'(1);
      end else begin
        bit_d  = cap_bit_c + BitW'(1);
        slot_d = cap_slot_c;
      end
    end

    if (emit_c) begin
      frame_data_d  = acc_d;
      frame_valid_d = 1'b1;
      seq_d         = seq_q + 8'd1;
    end

    err_short_d = short_evt_c | (err_short_q & ~err_clr);
    err_long_d  = long_evt_c | (err_long_q & ~err_clr);
  end

  // State and output registers.
  always_ff @(posedge i2s_bclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= HUNT;
      per_cnt_q     <= '0;
      bit_q         <= '0;
      slot_q        <= '0;
      acc_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      seq_q         <= '0;
      locked_q      <= 1'b0;
      lock_cnt_q    <= '0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      data_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      bit_q         <= bit_d;
      slot_q        <= slot_d;
      acc_q         <= acc_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      seq_q         <= seq_d;
      locked_q      <= locked_d;
      lock_cnt_q    <= lock_cnt_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
      data_q        <= i2s_data;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_seq   = seq_q;
  assign locked      = locked_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;

endmodule
